// File: rtl/adc_clock_sync_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : adc_clock_sync_ctrl
// Description : Phase-aligns the sample clocks of NUM_SLAVES slave ADCs to
//               the master ADC clock, one slave at a time. For each slave it
//               fires an ADC reset on a rotating phase tap, waits for the
//               DCMs to lock, requests clock samples and compares them with
//               a programmable good pattern. Retries per slave are bounded.
// Ports       :
//   dcm_psclk           - sole clock; all inputs are synchronous to it
//   ctrl_reset_n        - asynchronous active-low reset
//   resync              - one-cycle pulse, restarts alignment from slave 0
//   dcm_locked          - bit 0 master DCM, bit i+1 slave i DCM
//   sample_valid        - per-phase sample valid for the selected slave
//   sample_data         - per-phase sampled slave clock level
//   slave_sel           - slave currently being aligned (drives ext. muxes)
//   sampler_rst         - holds the external samplers in reset
//   sample_req          - sample request to the samplers
//   adc_reset_start     - one-hot, one-cycle reset trigger on the phase tap
//   adc_reset_block_rst - clears the external adc_reset blocks
//   slave_locked        - sticky per-slave aligned flags
//   retry_count         - failed attempts so far on the current slave
//   sync_done           - all slaves aligned
//   sync_fail           - some slave exhausted its retries
// Revision    : 1.0 - initial release
// ============================================================================
module adc_clock_sync_ctrl #(
    parameter int                    NUM_SLAVES   = 1,
    parameter int                    NUM_PHASES   = 4,
    parameter int                    INIT_DELAY   = 125000000,
    parameter int                    ADC_WAIT     = 2000,
    parameter int                    TIMEOUT      = 1024,
    parameter int                    MAX_RETRIES  = 16,
    parameter logic [NUM_PHASES-1:0] GOOD_PATTERN = 4'b0110,
    parameter logic [NUM_PHASES-1:0] CARE_MASK    = 4'b0110,
    parameter int                    CNT_WIDTH    = 32,
    localparam int                   SEL_W        = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1,
    localparam int                   RETRY_W      = $clog2(MAX_RETRIES + 1)
) (
    input  logic                   dcm_psclk,
    input  logic                   ctrl_reset_n,
    input  logic                   resync,
    input  logic [NUM_SLAVES:0]    dcm_locked,
    input  logic [NUM_PHASES-1:0]  sample_valid,
    input  logic [NUM_PHASES-1:0]  sample_data,
    output logic [SEL_W-1:0]       slave_sel,
    output logic                   sampler_rst,
    output logic                   sample_req,
    output logic [NUM_PHASES-1:0]  adc_reset_start,
    output logic                   adc_reset_block_rst,
    output logic [NUM_SLAVES-1:0]  slave_locked,
    output logic [RETRY_W-1:0]     retry_count,
    output logic                   sync_done,
    output logic                   sync_fail
);

    localparam int PH_W = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1;

    localparam logic [3:0] C_ST_INIT      = 4'd0;
    localparam logic [3:0] C_ST_RESET_ADC = 4'd1;
    localparam logic [3:0] C_ST_WAIT_ADC  = 4'd2;
    localparam logic [3:0] C_ST_WAIT_DCM  = 4'd3;
    localparam logic [3:0] C_ST_SAMPLE    = 4'd4;
    localparam logic [3:0] C_ST_DECIDE    = 4'd5;
    localparam logic [3:0] C_ST_RETRY     = 4'd6;
    localparam logic [3:0] C_ST_NEXT      = 4'd7;
    localparam logic [3:0] C_ST_DONE      = 4'd8;
    localparam logic [3:0] C_ST_FAIL      = 4'd9;

    logic [3:0]            r_state;
    logic [3:0]            w_next;
    logic [CNT_WIDTH-1:0]  r_cnt;
    logic [CNT_WIDTH-1:0]  w_cnt_inc;
    logic [PH_W-1:0]       r_phase;
    logic [PH_W-1:0]       w_phase_inc;
    logic [NUM_PHASES-1:0] r_capture;
    logic [NUM_PHASES-1:0] w_phase_onehot;
    logic [NUM_SLAVES-1:0] w_sel_onehot;
    logic [RETRY_W-1:0]    w_retry_inc;
    logic                  w_retry_max;
    logic                  w_resync_ok;
    logic                  w_dcms_locked;
    logic                  w_pattern_ok;
    logic                  w_last_slave;
    logic                  w_all_valid;

    // A dwell of N ends on the cycle the counter would step to N.
    assign w_cnt_inc      = r_cnt + 1'b1;
    assign w_phase_inc    = (r_phase == PH_W'(NUM_PHASES - 1)) ? '0 : r_phase + 1'b1;
    assign w_phase_onehot = {{(NUM_PHASES-1){1'b0}}, 1'b1} << r_phase;
    assign w_sel_onehot   = {{(NUM_SLAVES-1){1'b0}}, 1'b1} << slave_sel;
    assign w_retry_inc    = retry_count + 1'b1;
    assign w_retry_max    = (w_retry_inc == RETRY_W'(MAX_RETRIES));
    assign w_last_slave   = (slave_sel == SEL_W'(NUM_SLAVES - 1));
    assign w_all_valid    = &sample_valid;
    assign w_dcms_locked  = dcm_locked[0] && (|(dcm_locked[NUM_SLAVES:1] & w_sel_onehot));
    assign w_pattern_ok   = (((r_capture ^ GOOD_PATTERN) & CARE_MASK) == '0);

    // The power-up dwell runs regardless, and a reset pulse is never cut short.
    assign w_resync_ok    = resync && (r_state != C_ST_INIT) && (r_state != C_ST_RESET_ADC);

    always_comb begin
        w_next = r_state;
        case (r_state)
            C_ST_INIT: begin
                if (w_cnt_inc >= CNT_WIDTH'(INIT_DELAY)) w_next = C_ST_RESET_ADC;
            end
            C_ST_RESET_ADC: w_next = C_ST_WAIT_ADC;
            C_ST_WAIT_ADC: begin
                if (w_cnt_inc >= CNT_WIDTH'(ADC_WAIT)) w_next = C_ST_WAIT_DCM;
            end
            C_ST_WAIT_DCM: begin
                if (w_dcms_locked)                         w_next = C_ST_SAMPLE;
                else if (w_cnt_inc >= CNT_WIDTH'(TIMEOUT)) w_next = C_ST_RETRY;
            end
            C_ST_SAMPLE: begin
                if (w_all_valid)                           w_next = C_ST_DECIDE;
                else if (w_cnt_inc >= CNT_WIDTH'(TIMEOUT)) w_next = C_ST_RETRY;
            end
            C_ST_DECIDE: w_next = w_pattern_ok ? C_ST_NEXT : C_ST_RETRY;
            C_ST_RETRY:  w_next = w_retry_max ? C_ST_FAIL : C_ST_RESET_ADC;
            C_ST_NEXT:   w_next = w_last_slave ? C_ST_DONE : C_ST_RESET_ADC;
            C_ST_DONE:   w_next = C_ST_DONE;
            C_ST_FAIL:   w_next = C_ST_FAIL;
            default:     w_next = C_ST_INIT;
        endcase
        if (w_resync_ok) w_next = C_ST_RESET_ADC;
    end

    // State, dwell counter and per-slave bookkeeping.
    always_ff @(posedge dcm_psclk or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            r_state      <= C_ST_INIT;
            r_cnt        <= '0;
            r_phase      <= '0;
            r_capture    <= '0;
            slave_sel    <= '0;
            retry_count  <= '0;
            slave_locked <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= (w_next != r_state) ? '0 : w_cnt_inc;
            if (w_resync_ok) begin
                slave_locked <= '0;
                slave_sel    <= '0;
                r_phase      <= '0;
                retry_count  <= '0;
            end else begin
                case (r_state)
                    C_ST_SAMPLE: begin
                        if (w_all_valid) r_capture <= sample_data;
                    end
                    C_ST_DECIDE: begin
                        if (w_pattern_ok) slave_locked <= slave_locked | w_sel_onehot;
                    end
                    C_ST_RETRY: begin
                        retry_count <= w_retry_inc;
                        r_phase     <= w_phase_inc;
                    end
                    C_ST_NEXT: begin
                        if (!w_last_slave) begin
                            slave_sel   <= slave_sel + 1'b1;
                            r_phase     <= '0;
                            retry_count <= '0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Registered decode of the current state. The done/fail flags drop on the
    // same edge that accepts a resync so they never outlive the restart.
    always_ff @(posedge dcm_psclk or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            sampler_rst         <= 1'b1;
            sample_req          <= 1'b0;
            adc_reset_start     <= '0;
            adc_reset_block_rst <= 1'b0;
            sync_done           <= 1'b0;
            sync_fail           <= 1'b0;
        end else begin
            sampler_rst         <= w_resync_ok ||
                                   !((r_state == C_ST_SAMPLE) || (r_state == C_ST_DECIDE) ||
                                     (r_state == C_ST_DONE));
            sample_req          <= !w_resync_ok && (r_state == C_ST_SAMPLE);
            adc_reset_start     <= (r_state == C_ST_RESET_ADC) ? w_phase_onehot : '0;
            adc_reset_block_rst <= (r_state == C_ST_DECIDE) || (r_state == C_ST_RETRY);
            sync_done           <= !w_resync_ok && (r_state == C_ST_DONE);
            sync_fail           <= !w_resync_ok && (r_state == C_ST_FAIL);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_adc_clock_sync_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_adc_clock_sync_ctrl
// Description : Directed self-checking bench for adc_clock_sync_ctrl with
//               two slaves, four phases and short dwells.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adc_clock_sync_ctrl;

    logic       clk = 1'b0;
    logic       ctrl_reset_n = 1'b0;
    logic       resync = 1'b0;
    logic [2:0] dcm_locked = 3'b111;
    logic [3:0] sample_valid = 4'h0;
    logic [3:0] sample_data = 4'h0;
    logic [0:0] slave_sel;
    logic       sampler_rst;
    logic       sample_req;
    logic [3:0] adc_reset_start;
    logic       adc_reset_block_rst;
    logic [1:0] slave_locked;
    logic [1:0] retry_count;
    logic       sync_done;
    logic       sync_fail;

    adc_clock_sync_ctrl #(
        .NUM_SLAVES   (2),
        .NUM_PHASES   (4),
        .INIT_DELAY   (10),
        .ADC_WAIT     (4),
        .TIMEOUT      (8),
        .MAX_RETRIES  (3),
        .GOOD_PATTERN (4'b0110),
        .CARE_MASK    (4'b0110),
        .CNT_WIDTH    (16)
    ) dut (
        .dcm_psclk           (clk),
        .ctrl_reset_n        (ctrl_reset_n),
        .resync              (resync),
        .dcm_locked          (dcm_locked),
        .sample_valid        (sample_valid),
        .sample_data         (sample_data),
        .slave_sel           (slave_sel),
        .sampler_rst         (sampler_rst),
        .sample_req          (sample_req),
        .adc_reset_start     (adc_reset_start),
        .adc_reset_block_rst (adc_reset_block_rst),
        .slave_locked        (slave_locked),
        .retry_count         (retry_count),
        .sync_done           (sync_done),
        .sync_fail           (sync_fail)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int t0    = 0;
    int n_att = 0;
    int bad_until = 0;
    int req_cnt = 0;

    logic [3:0] pq_val[$];
    int         pq_cyc[$];
    logic [1:0] lq_val[$];
    int         lq_cyc[$];
    logic [1:0] lq_retry[$];
    logic       prev_req  = 1'b0;
    logic [1:0] prev_lock = 2'b00;

    always @(posedge clk) cyc <= cyc + 1;

    // Observation log plus a sampler model: valid for one cycle after each
    // rising sample_req, data bad while the attempt index is below bad_until.
    always @(negedge clk) begin
        if (adc_reset_start != 4'h0) begin
            pq_val.push_back(adc_reset_start);
            pq_cyc.push_back(cyc);
        end
        if (slave_locked != prev_lock) begin
            lq_val.push_back(slave_locked);
            lq_cyc.push_back(cyc);
            lq_retry.push_back(retry_count);
        end
        prev_lock = slave_locked;
        if (sample_req) req_cnt++;
        if (sample_req && !prev_req) begin
            sample_valid = 4'hF;
            sample_data  = (n_att < bad_until) ? 4'b1001 : 4'b0110;
            n_att++;
        end else begin
            sample_valid = 4'h0;
        end
        prev_req = sample_req;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_term(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (sync_done || sync_fail) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic pulse_resync();
        @(negedge clk);
        resync = 1'b1;
        @(negedge clk);
        resync = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        ctrl_reset_n = 1'b0;
        repeat (3) tick();
        total++;
        if (sampler_rst !== 1'b1) begin bad++; $display("FAIL reset_sampler_rst got=%b exp=1", sampler_rst); end
        total++;
        if ({sample_req, adc_reset_start, adc_reset_block_rst} !== 6'b0) begin
            bad++; $display("FAIL reset_ctrl_outs got=%b exp=000000", {sample_req, adc_reset_start, adc_reset_block_rst});
        end
        total++;
        if ({slave_sel, slave_locked, retry_count, sync_done, sync_fail} !== 7'b0) begin
            bad++; $display("FAIL reset_status got=%b exp=0000000", {slave_sel, slave_locked, retry_count, sync_done, sync_fail});
        end
        @(negedge clk);
        ctrl_reset_n = 1'b1;
        t0 = cyc;
    endtask

    task automatic test_nominal();
        int pb;
        int lb;
        bit ok;
        pb = pq_val.size();
        lb = lq_val.size();
        bad_until = n_att;
        wait_term(200, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL nominal_timeout got=none exp=sync_done"); end
        total++;
        if (cyc - t0 !== 31) begin bad++; $display("FAIL nominal_done_cycle got=%0d exp=31", cyc - t0); end
        total++;
        if (pq_val.size() - pb != 2) begin
            bad++; $display("FAIL nominal_pulse_count got=%0d exp=2", pq_val.size() - pb);
        end else begin
            if (pq_val[pb] !== 4'b0001 || pq_cyc[pb] - t0 != 11) begin
                bad++; $display("FAIL nominal_pulse0 got=%b@%0d exp=0001@11", pq_val[pb], pq_cyc[pb] - t0);
            end
            total++;
            if (pq_val[pb+1] !== 4'b0001 || pq_cyc[pb+1] - t0 != 21) begin
                bad++; $display("FAIL nominal_pulse1 got=%b@%0d exp=0001@21", pq_val[pb+1], pq_cyc[pb+1] - t0);
            end
        end
        total++;
        if (lq_val.size() - lb != 2) begin
            bad++; $display("FAIL nominal_lock_count got=%0d exp=2", lq_val.size() - lb);
        end else begin
            if (lq_val[lb] !== 2'b01 || lq_cyc[lb] - t0 != 19) begin
                bad++; $display("FAIL nominal_lock0 got=%b@%0d exp=01@19", lq_val[lb], lq_cyc[lb] - t0);
            end
            total++;
            if (lq_val[lb+1] !== 2'b11 || lq_cyc[lb+1] - t0 != 29) begin
                bad++; $display("FAIL nominal_lock1 got=%b@%0d exp=11@29", lq_val[lb+1], lq_cyc[lb+1] - t0);
            end
        end
        total++;
        if ({sync_done, sync_fail, retry_count, sampler_rst} !== 5'b10000) begin
            bad++; $display("FAIL nominal_final got=%b exp=10000", {sync_done, sync_fail, retry_count, sampler_rst});
        end
    endtask

    task automatic test_resync_done();
        bit ok;
        bad_until = n_att;
        pulse_resync();
        total++;
        if ({sync_done, slave_locked, adc_reset_start} !== 7'b0) begin
            bad++; $display("FAIL resync_clear got=%b exp=0000000", {sync_done, slave_locked, adc_reset_start});
        end
        tick();
        total++;
        if (adc_reset_start !== 4'b0001) begin
            bad++; $display("FAIL resync_pulse got=%b exp=0001", adc_reset_start);
        end
        wait_term(200, ok);
        total++;
        if (!ok || sync_done !== 1'b1 || slave_locked !== 2'b11) begin
            bad++; $display("FAIL resync_realign got=%b/%b exp=1/11", sync_done, slave_locked);
        end
    endtask

    task automatic test_retry();
        int pb;
        int lb;
        bit ok;
        bad_until = n_att + 2;
        pulse_resync();
        pb = pq_val.size();
        lb = lq_val.size();
        wait_term(300, ok);
        total++;
        if (!ok || sync_done !== 1'b1) begin bad++; $display("FAIL retry_done got=%b exp=1", sync_done); end
        total++;
        if (pq_val.size() - pb != 4) begin
            bad++; $display("FAIL retry_pulse_count got=%0d exp=4", pq_val.size() - pb);
        end else if ({pq_val[pb], pq_val[pb+1], pq_val[pb+2], pq_val[pb+3]} !== 16'b0001_0010_0100_0001) begin
            bad++; $display("FAIL retry_pulse_seq got=%b %b %b %b exp=0001 0010 0100 0001",
                            pq_val[pb], pq_val[pb+1], pq_val[pb+2], pq_val[pb+3]);
        end
        total++;
        if (lq_val.size() - lb != 2) begin
            bad++; $display("FAIL retry_lock_count got=%0d exp=2", lq_val.size() - lb);
        end else if (lq_val[lb] !== 2'b01 || lq_retry[lb] !== 2'd2) begin
            bad++; $display("FAIL retry_at_lock0 got=%b/%0d exp=01/2", lq_val[lb], lq_retry[lb]);
        end
        total++;
        if (retry_count !== 2'd0) begin bad++; $display("FAIL retry_slave1 got=%0d exp=0", retry_count); end
    endtask

    task automatic test_dcm_timeout();
        int pb;
        int p_cyc;
        int req0;
        bit found;
        bit ok;
        bad_until = n_att;
        dcm_locked = 3'b011;
        pulse_resync();
        pb = pq_val.size();
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (pq_val.size() - pb >= 2) begin found = 1'b1; break; end
        end
        total++;
        if (!found) begin
            bad++; $display("FAIL dcm_slave1_pulse got=none exp=pulse");
        end else begin
            p_cyc = pq_cyc[pb+1];
            req0  = req_cnt;
            found = 1'b0;
            for (int i = 0; i < 30; i++) begin
                if (retry_count == 2'd1) begin found = 1'b1; break; end
                tick();
            end
            total++;
            if (!found || cyc != p_cyc + 13) begin
                bad++; $display("FAIL dcm_timeout_cycle got=%0d exp=%0d", cyc - p_cyc, 13);
            end
            total++;
            if (req_cnt != req0) begin bad++; $display("FAIL dcm_no_sample_req got=%0d exp=0", req_cnt - req0); end
        end
        dcm_locked = 3'b111;
        wait_term(200, ok);
        total++;
        if (!ok || {sync_done, retry_count, slave_locked} !== 5'b1_01_11) begin
            bad++; $display("FAIL dcm_recover got=%b exp=10111", {sync_done, retry_count, slave_locked});
        end
        total++;
        if (pq_val[pq_val.size()-1] !== 4'b0010) begin
            bad++; $display("FAIL dcm_retry_phase got=%b exp=0010", pq_val[pq_val.size()-1]);
        end
    endtask

    task automatic test_fail();
        int pb;
        bit ok;
        bad_until = n_att + 1000;
        pulse_resync();
        pb = pq_val.size();
        wait_term(300, ok);
        total++;
        if (!ok || {sync_fail, sync_done, slave_locked, retry_count} !== 6'b10_00_11) begin
            bad++; $display("FAIL fail_flags got=%b exp=100011", {sync_fail, sync_done, slave_locked, retry_count});
        end
        total++;
        if (pq_val.size() - pb != 3) begin
            bad++; $display("FAIL fail_pulse_count got=%0d exp=3", pq_val.size() - pb);
        end else if ({pq_val[pb], pq_val[pb+1], pq_val[pb+2]} !== 12'b0001_0010_0100) begin
            bad++; $display("FAIL fail_pulse_seq got=%b %b %b exp=0001 0010 0100", pq_val[pb], pq_val[pb+1], pq_val[pb+2]);
        end
    endtask

    task automatic test_async_reset();
        bit found;
        bad_until = n_att;
        pulse_resync();
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (sample_req) begin found = 1'b1; break; end
            tick();
        end
        total++;
        if (!found) begin bad++; $display("FAIL arst_reach_sample got=none exp=sample_req"); end
        #2;
        ctrl_reset_n = 1'b0;
        #1;
        total++;
        if ({sample_req, sampler_rst} !== 2'b01) begin
            bad++; $display("FAIL arst_sample got=%b exp=01", {sample_req, sampler_rst});
        end
        @(negedge clk);
        ctrl_reset_n = 1'b1;
        t0 = cyc;
        found = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (adc_reset_start != 4'h0) begin found = 1'b1; break; end
        end
        total++;
        if (!found || cyc - t0 != 11 || adc_reset_start !== 4'b0001) begin
            bad++; $display("FAIL arst_init_dwell got=%b@%0d exp=0001@11", adc_reset_start, cyc - t0);
        end
        ctrl_reset_n = 1'b0;
        #1;
        total++;
        if (adc_reset_start !== 4'b0000) begin
            bad++; $display("FAIL arst_pulse_drop got=%b exp=0000", adc_reset_start);
        end
        @(negedge clk);
        ctrl_reset_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_resync_done();
        test_retry();
        test_dcm_timeout();
        test_fail();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
